// File: rtl/conv_layer_sequencer_if.sv
// Activation input handshake for the binarised conv layer sequencer.
// The pixel source drives through the master modport, the sequencer
// consumes through the slave modport.
interface conv_layer_sequencer_if #(
  parameter int CH_IN = 64
) ();
  logic [CH_IN-1:0] act_in;
  logic             act_in_valid;
  logic             act_in_ready;

  modport master (output act_in, output act_in_valid, input act_in_ready);
  modport slave  (input act_in, input act_in_valid, output act_in_ready);
endinterface

// File: rtl/conv_layer_sequencer.sv
// Streaming control for one binarised conv layer: accepts activation
// pixels, issues one line-buffer shift per slot of FOLD cycles, appends
// zero flush pixels for the padded border, and times the threshold /
// max-pool / output valid strobes through short valid pipes.
// Optional feature: define CONV_SEQ_STALL_CNT_EN to add a saturating
// stall_cnt_o output counting RUN cycles starved of input pixels.
module conv_layer_sequencer #(
  parameter int CH_IN      = 64,
  parameter int W_IN       = 32,
  parameter int H_IN       = 32,
  parameter int PAD        = 1,
  parameter int FOLD       = 2,
  parameter int TH_LAT     = 2,
  parameter int MAXPOOL_EN = 1,
  parameter int KMP        = 2,
  parameter int MP_LAT     = 2,
  localparam int FOLDW     = (FOLD > 1) ? $clog2(FOLD) : 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start_i,
  conv_layer_sequencer_if.slave      act_if,
  output logic [CH_IN-1:0]           stream_act_o,
  output logic                       stream_act_en_o,
  output logic [FOLDW-1:0]           fold_add_o,
  output logic                       stream_maxpool_en_o,
  output logic                       out_valid_o,
  output logic                       busy_o,
`ifdef CONV_SEQ_STALL_CNT_EN
  output logic [15:0]                stall_cnt_o,
`endif
  output logic                       done_o
);

  localparam int WIN_LAT = PAD * W_IN + PAD;
  localparam int NPIX    = H_IN * W_IN;
  localparam int NSLOT   = NPIX + WIN_LAT;
  localparam int CNTW    = $clog2(NSLOT + 1);
  localparam int COLW    = (W_IN > 1) ? $clog2(W_IN) : 1;
  localparam int ROWW    = (H_IN > 1) ? $clog2(H_IN) : 1;
  localparam int MPD     = TH_LAT + MP_LAT;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_DRAIN} state_t;

  state_t            state_q, state_d;
  logic [FOLDW-1:0]  fold_q, fold_d;
  logic [CNTW-1:0]   pix_q, pix_d;
  logic [TH_LAT-1:0] th_pipe_q;

  logic frame_start;
  logic slot_start;
  logic in_slot;
  logic slot_end;
  logic produces;
  logic pipe_empty;

  // A slot begins on fold 0 when a pixel is handed over (RUN) or
  // unconditionally during the border flush; once begun it never stalls.
  assign frame_start = (state_q == S_IDLE) && start_i;
  assign slot_start  = (fold_q == '0) &&
                       (((state_q == S_RUN) && act_if.act_in_valid) || (state_q == S_FLUSH));
  assign in_slot     = slot_start || (fold_q != '0);
  assign slot_end    = in_slot && (fold_q == FOLDW'(FOLD - 1));
  // The first WIN_LAT slots only prime the line buffer.
  assign produces    = (pix_q >= CNTW'(WIN_LAT));

  assign act_if.act_in_ready = (state_q == S_RUN) && (fold_q == '0);
  assign stream_act_en_o     = slot_start;
  assign stream_act_o        = (slot_start && (state_q == S_RUN)) ? act_if.act_in : '0;
  assign fold_add_o          = fold_q;
  assign busy_o              = (state_q != S_IDLE);
  assign stream_maxpool_en_o = th_pipe_q[TH_LAT-1];

  // Next-state, fold sweep, slot counting and the done strobe.
  always_comb begin
    state_d = state_q;
    fold_d  = fold_q;
    pix_d   = pix_q;
    done_o  = 1'b0;
    if (in_slot) begin
      fold_d = slot_end ? '0 : fold_q + FOLDW'(1);
    end
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = S_RUN;
          pix_d   = '0;
          fold_d  = '0;
        end
      end
      S_RUN: begin
        if (slot_end) begin
          pix_d = pix_q + CNTW'(1);
          if (pix_q == CNTW'(NPIX - 1)) begin
            state_d = (WIN_LAT == 0) ? S_DRAIN : S_FLUSH;
          end
        end
      end
      S_FLUSH: begin
        if (slot_end) begin
          pix_d = pix_q + CNTW'(1);
          if (pix_q == CNTW'(NSLOT - 1)) begin
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (pipe_empty) begin
          done_o  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, fold and slot counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      fold_q  <= '0;
      pix_q   <= '0;
    end else begin
      state_q <= state_d;
      fold_q  <= fold_d;
      pix_q   <= pix_d;
    end
  end

  // Threshold-complete pipe: one bit per producing slot, TH_LAT deep.
  always_ff @(posedge clk) begin
    if (reset) begin
      th_pipe_q <= '0;
    end else begin
      th_pipe_q[0] <= slot_end && produces;
      for (int i = 1; i < TH_LAT; i++) begin
        th_pipe_q[i] <= th_pipe_q[i-1];
      end
    end
  end

  generate
    if (MAXPOOL_EN != 0) begin : g_mp
      logic [COLW-1:0] col_q;
      logic [ROWW-1:0] row_q;
      logic [MPD-1:0]  mp_pipe_q;
      logic            corner;

      // Only the bottom-right pixel of each KMP x KMP window yields output.
      assign corner = ((32'(row_q) % KMP) == KMP - 1) && ((32'(col_q) % KMP) == KMP - 1);

      // Output position tracker, advanced once per producing slot.
      always_ff @(posedge clk) begin
        if (reset || frame_start) begin
          col_q <= '0;
          row_q <= '0;
        end else if (slot_end && produces) begin
          if (col_q == COLW'(W_IN - 1)) begin
            col_q <= '0;
            row_q <= (row_q == ROWW'(H_IN - 1)) ? '0 : row_q + ROWW'(1);
          end else begin
            col_q <= col_q + COLW'(1);
          end
        end
      end

      // Max-pool output pipe: corner slots travel TH_LAT+MP_LAT cycles.
      always_ff @(posedge clk) begin
        if (reset) begin
          mp_pipe_q <= '0;
        end else begin
          mp_pipe_q[0] <= slot_end && produces && corner;
          for (int i = 1; i < MPD; i++) begin
            mp_pipe_q[i] <= mp_pipe_q[i-1];
          end
        end
      end

      assign out_valid_o = mp_pipe_q[MPD-1];
      assign pipe_empty  = (th_pipe_q == '0) && (mp_pipe_q == '0);
    end else begin : g_th_out
      assign out_valid_o = th_pipe_q[TH_LAT-1];
      assign pipe_empty  = (th_pipe_q == '0);
    end
  endgenerate

`ifdef CONV_SEQ_STALL_CNT_EN
  logic [15:0] stall_cnt_q;

  // Saturating count of RUN cycles waiting on an absent input pixel.
  always_ff @(posedge clk) begin
    if (reset || frame_start) begin
      stall_cnt_q <= '0;
    end else if ((state_q == S_RUN) && act_if.act_in_ready && !act_if.act_in_valid &&
                 (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_conv_layer_sequencer.sv
// Bench for conv_layer_sequencer on a 4x4 frame, PAD=1 (5 flush slots).
// Three instances run side by side from the same stimulus:
//   d0: FOLD=2, MAXPOOL_EN=0   d1: FOLD=2, MAXPOOL_EN=1   d2: FOLD=1, MAXPOOL_EN=0
module tb_conv_layer_sequencer;
  localparam int CH = 64;

  logic clk = 1'b0;
  logic reset;
  logic start;
  logic vld;
  logic clr;

  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;

  // DUT observation arrays
  logic [CH-1:0] sa [3];
  logic          en [3];
  logic [0:0]    fa [3];
  logic          mp [3];
  logic          ov [3];
  logic          bz [3];
  logic          dn [3];
  logic          rdy [3];
`ifdef CONV_SEQ_STALL_CNT_EN
  logic [15:0]   sc [3];
`endif

  int src_cnt [3];

  function automatic logic [63:0] pix_of(input int n);
    return 64'hC0DE_0000_0000_0000 | 64'(n + 1);
  endfunction

  conv_layer_sequencer_if #(.CH_IN(CH)) aif0 ();
  conv_layer_sequencer_if #(.CH_IN(CH)) aif1 ();
  conv_layer_sequencer_if #(.CH_IN(CH)) aif2 ();

  assign aif0.act_in = pix_of(src_cnt[0]);
  assign aif1.act_in = pix_of(src_cnt[1]);
  assign aif2.act_in = pix_of(src_cnt[2]);
  assign aif0.act_in_valid = vld;
  assign aif1.act_in_valid = vld;
  assign aif2.act_in_valid = vld;
  assign rdy[0] = aif0.act_in_ready;
  assign rdy[1] = aif1.act_in_ready;
  assign rdy[2] = aif2.act_in_ready;

  conv_layer_sequencer #(.CH_IN(CH), .W_IN(4), .H_IN(4), .PAD(1), .FOLD(2), .TH_LAT(2),
                         .MAXPOOL_EN(0), .KMP(2), .MP_LAT(2)) d0 (
    .clk(clk), .reset(reset), .start_i(start), .act_if(aif0),
    .stream_act_o(sa[0]), .stream_act_en_o(en[0]), .fold_add_o(fa[0]),
    .stream_maxpool_en_o(mp[0]), .out_valid_o(ov[0]), .busy_o(bz[0]),
`ifdef CONV_SEQ_STALL_CNT_EN
    .stall_cnt_o(sc[0]),
`endif
    .done_o(dn[0]));

  conv_layer_sequencer #(.CH_IN(CH), .W_IN(4), .H_IN(4), .PAD(1), .FOLD(2), .TH_LAT(2),
                         .MAXPOOL_EN(1), .KMP(2), .MP_LAT(2)) d1 (
    .clk(clk), .reset(reset), .start_i(start), .act_if(aif1),
    .stream_act_o(sa[1]), .stream_act_en_o(en[1]), .fold_add_o(fa[1]),
    .stream_maxpool_en_o(mp[1]), .out_valid_o(ov[1]), .busy_o(bz[1]),
`ifdef CONV_SEQ_STALL_CNT_EN
    .stall_cnt_o(sc[1]),
`endif
    .done_o(dn[1]));

  conv_layer_sequencer #(.CH_IN(CH), .W_IN(4), .H_IN(4), .PAD(1), .FOLD(1), .TH_LAT(2),
                         .MAXPOOL_EN(0), .KMP(2), .MP_LAT(2)) d2 (
    .clk(clk), .reset(reset), .start_i(start), .act_if(aif2),
    .stream_act_o(sa[2]), .stream_act_en_o(en[2]), .fold_add_o(fa[2]),
    .stream_maxpool_en_o(mp[2]), .out_valid_o(ov[2]), .busy_o(bz[2]),
`ifdef CONV_SEQ_STALL_CNT_EN
    .stall_cnt_o(sc[2]),
`endif
    .done_o(dn[2]));

  // Pixel source: next pixel value advances on each accepted handshake.
  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (clr) src_cnt[i] <= 0;
      else if (rdy[i] && vld) src_cnt[i] <= src_cnt[i] + 1;
    end
  end

  // Event monitor, sampled on the falling edge.
  int n_hs [3], n_en [3], n_zero [3], seq_err [3], en_bad [3], n_f1 [3];
  int n_mp [3], n_ov [3], n_busy [3], first_ov [3], n_done [3], stall_at_done [3];

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (clr) begin
        n_hs[i] = 0; n_en[i] = 0; n_zero[i] = 0; seq_err[i] = 0; en_bad[i] = 0;
        n_f1[i] = 0; n_mp[i] = 0; n_ov[i] = 0; n_busy[i] = 0; first_ov[i] = -1;
        n_done[i] = 0; stall_at_done[i] = 0;
      end else begin
        if (rdy[i] && vld) n_hs[i]++;
        if (en[i]) begin
          if (sa[i] !== ((n_en[i] < 16) ? pix_of(n_en[i]) : 64'd0)) seq_err[i]++;
          if (sa[i] == '0) n_zero[i]++;
          if (fa[i] != 1'b0) en_bad[i]++;
          n_en[i]++;
        end
        if (fa[i] != 1'b0) n_f1[i]++;
        if (mp[i]) n_mp[i]++;
        if (ov[i]) begin
          if (first_ov[i] < 0) first_ov[i] = n_busy[i];
          n_ov[i]++;
        end
        if (dn[i]) begin
          n_done[i]++;
`ifdef CONV_SEQ_STALL_CNT_EN
          stall_at_done[i] = int'(sc[i]);
`endif
        end
        if (bz[i]) n_busy[i]++;
      end
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_idle_outputs(input string phase);
    for (int i = 0; i < 3; i++) begin
      check_eq($sformatf("%s_d%0d_busy", phase, i), 64'(bz[i]), 64'd0);
      check_eq($sformatf("%s_d%0d_ready", phase, i), 64'(rdy[i]), 64'd0);
      check_eq($sformatf("%s_d%0d_act_en", phase, i), 64'(en[i]), 64'd0);
      check_eq($sformatf("%s_d%0d_stream_act", phase, i), sa[i], 64'd0);
      check_eq($sformatf("%s_d%0d_fold", phase, i), 64'(fa[i]), 64'd0);
      check_eq($sformatf("%s_d%0d_mp_en", phase, i), 64'(mp[i]), 64'd0);
      check_eq($sformatf("%s_d%0d_out_valid", phase, i), 64'(ov[i]), 64'd0);
      check_eq($sformatf("%s_d%0d_done", phase, i), 64'(dn[i]), 64'd0);
`ifdef CONV_SEQ_STALL_CNT_EN
      check_eq($sformatf("%s_d%0d_stall_cnt", phase, i), 64'(sc[i]), 64'd0);
`endif
    end
  endtask

  // extra = stall cycles injected at a slot boundary of every instance.
  task automatic check_frame(input string name, input int extra);
    int exp_busy, exp_first, exp_ov, exp_f1;
    for (int i = 0; i < 3; i++) begin
      exp_busy  = (i == 0) ? 45 : (i == 1) ? 47 : 24;
      exp_first = (i == 0) ? 13 + extra : (i == 1) ? 25 + extra : 7;
      exp_ov    = (i == 1) ? 4 : 16;
      exp_f1    = (i == 2) ? 0 : 21;
      check_eq($sformatf("%s_d%0d_handshakes", name, i), 64'(n_hs[i]), 64'd16);
      check_eq($sformatf("%s_d%0d_act_en", name, i), 64'(n_en[i]), 64'd21);
      check_eq($sformatf("%s_d%0d_zero_pix", name, i), 64'(n_zero[i]), 64'd5);
      check_eq($sformatf("%s_d%0d_pix_order_err", name, i), 64'(seq_err[i]), 64'd0);
      check_eq($sformatf("%s_d%0d_en_off_fold0", name, i), 64'(en_bad[i]), 64'd0);
      check_eq($sformatf("%s_d%0d_fold1_cycles", name, i), 64'(n_f1[i]), 64'(exp_f1));
      check_eq($sformatf("%s_d%0d_mp_en", name, i), 64'(n_mp[i]), 64'd16);
      check_eq($sformatf("%s_d%0d_out_valid", name, i), 64'(n_ov[i]), 64'(exp_ov));
      check_eq($sformatf("%s_d%0d_first_ov", name, i), 64'(first_ov[i]), 64'(exp_first));
      check_eq($sformatf("%s_d%0d_busy_cycles", name, i), 64'(n_busy[i]), 64'(exp_busy + extra));
      check_eq($sformatf("%s_d%0d_done", name, i), 64'(n_done[i]), 64'd1);
`ifdef CONV_SEQ_STALL_CNT_EN
      check_eq($sformatf("%s_d%0d_stall_cnt", name, i), 64'(stall_at_done[i]), 64'(extra));
`endif
      $display("[TB] %s d%0d: hs=%0d en=%0d mp=%0d ov=%0d busy=%0d first_ov=%0d",
               name, i, n_hs[i], n_en[i], n_mp[i], n_ov[i], n_busy[i], first_ov[i]);
    end
  endtask

  // One frame; drop_at = first of 3 starved cycles, restart_at = stray start in RUN.
  task automatic run_frame(input string name, input int drop_at, input int restart_at, input int extra);
    int  k;
    bit  all_done;
    @(posedge clk); #1;
    start = 1'b1;
    clr   = 1'b1;
    @(posedge clk); #1;
    start    = 1'b0;
    clr      = 1'b0;
    k        = 0;
    all_done = 1'b0;
    while (!all_done && k < 150) begin
      vld   = !((drop_at >= 0) && (k >= drop_at) && (k < drop_at + 3));
      start = (k == restart_at);
      @(posedge clk); #1;
      k++;
      all_done = (n_done[0] > 0) && (n_done[1] > 0) && (n_done[2] > 0);
    end
    start = 1'b0;
    vld   = 1'b1;
    check_eq({name, "_frame_done"}, 64'(all_done), 64'd1);
    repeat (4) begin
      @(posedge clk); #1;
    end
    check_frame(name, extra);
  endtask

  initial begin
    int guard;
    reset = 1'b1;
    start = 1'b0;
    vld   = 1'b1;
    clr   = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check_idle_outputs("reset");
    @(posedge clk); #1;
    reset = 1'b0;
    clr   = 1'b0;

    // Reset mid-RUN after three pixels, then the next frame must replay cleanly.
    start = 1'b1;
    clr   = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    clr   = 1'b0;
    guard = 0;
    while (n_hs[0] < 3 && guard < 40) begin
      @(posedge clk); #1;
      guard++;
    end
    check_eq("midrun_three_pixels", 64'(n_hs[0]), 64'd3);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check_idle_outputs("midrun_reset");
    $display("[TB] mid-run reset after %0d pixels", n_hs[0]);

    run_frame("steady", -1, -1, 0);
    run_frame("stall3", 8, -1, 3);
    run_frame("restart", -1, 6, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
